// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the address-region layout used by the decoder.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_t;

   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'd0,
      HSIZE_HALF = 3'd1,
      HSIZE_WORD = 3'd2
   } hsize_t;

   typedef enum logic {
      HRESP_OKAY  = 1'b0,
      HRESP_ERROR = 1'b1
   } hresp_t;

   // Top address bits select the slave region; everything below is local offset.
   localparam int REGION_BITS = 4;

endpackage

// File: rtl/ahb_mem_array.sv
// Word array with per-byte write enables and an asynchronous read port.
module ahb_mem_array #(
   parameter  int DEPTH      = 1024,
   parameter  int DATA_WIDTH = 32,
   localparam int AW         = $clog2(DEPTH),
   localparam int LANES      = DATA_WIDTH / 8
) (
   input  logic                  clk_sys,
   input  logic                  we,
   input  logic [LANES-1:0]      be,
   input  logic [AW-1:0]         addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk_sys) begin
      for (int i = 0; i < LANES; i++) begin
         if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory responder: registered address phase, fixed wait states,
// byte/halfword/word access to a local word array, two-cycle ERROR response.
//
// state   | meaning
// IDLE    | no data phase pending
// WAIT    | counting wait states (Hreadyout low)
// DONE    | OKAY completion; read data valid, write commits at end
// ERR1    | first ERROR cycle (Hreadyout low)
// ERR2    | second ERROR cycle (Hreadyout high)
module ahb_slave_mem
   import ahb_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int MEM_DEPTH   = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic                  Hclk,
   input  logic                  Hreset,
   input  logic                  Hsel,
   input  logic [ADDR_WIDTH-1:0] Haddr,
   input  logic [1:0]            Htrans,
   input  logic                  Hwrite,
   input  logic [2:0]            Hsize,
   input  logic [DATA_WIDTH-1:0] Hwdata,
   input  logic                  Hready,
   output logic                  Hreadyout,
   output logic                  Hresp,
   output logic [DATA_WIDTH-1:0] Hrdata
);

   localparam int IDX_BITS = ADDR_WIDTH - REGION_BITS - 2;
   localparam int AW       = $clog2(MEM_DEPTH);
   localparam logic [IDX_BITS-1:0] DEPTH_IDX = IDX_BITS'(MEM_DEPTH);
   localparam logic [2:0] CNT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

   typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DONE, ST_ERR1, ST_ERR2} state_t;

   state_t                state, state_nxt;
   logic [2:0]            cnt, cnt_nxt;
   logic [AW-1:0]         idx_q;
   logic [1:0]            lane_q;
   logic [2:0]            size_q;
   logic                  write_q;
   logic                  accept, cap, addr_err, mem_we;
   logic [IDX_BITS-1:0]   word_idx;
   logic [3:0]            be;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  unused_bits;

   assign word_idx    = Haddr[ADDR_WIDTH-REGION_BITS-1:2];
   assign unused_bits = &{1'b0, Haddr[ADDR_WIDTH-1:ADDR_WIDTH-REGION_BITS]};
   assign accept      = Hsel & Hready & ((Htrans == HTRANS_NONSEQ) | (Htrans == HTRANS_SEQ));
   // WAIT and ERR1 hold the bus low, so only the other states can see an accept.
   assign cap         = accept & (state != ST_WAIT) & (state != ST_ERR1);

   always_comb begin
      addr_err = 1'b0;
      if (Hsize > HSIZE_WORD)                           addr_err = 1'b1;
      if ((Hsize == HSIZE_HALF) && Haddr[0])            addr_err = 1'b1;
      if ((Hsize == HSIZE_WORD) && (Haddr[1:0] != 2'b0)) addr_err = 1'b1;
      if (word_idx >= DEPTH_IDX)                        addr_err = 1'b1;
   end

   always_comb begin
      if (size_q == HSIZE_BYTE)      be = 4'b0001 << lane_q;
      else if (size_q == HSIZE_HALF) be = lane_q[1] ? 4'b1100 : 4'b0011;
      else                           be = 4'b1111;
   end

   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         state   <= ST_IDLE;
         cnt     <= 3'd0;
         idx_q   <= '0;
         lane_q  <= 2'd0;
         size_q  <= 3'd0;
         write_q <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (cap) begin
            idx_q   <= word_idx[AW-1:0];
            lane_q  <= Haddr[1:0];
            size_q  <= Hsize;
            write_q <= Hwrite;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      Hreadyout = 1'b1;
      Hresp     = HRESP_OKAY;
      Hrdata    = '0;
      mem_we    = 1'b0;
      case (state)
         ST_WAIT: begin
            Hreadyout = 1'b0;
            if (cnt == 3'd0) state_nxt = ST_DONE;
            else             cnt_nxt   = cnt - 3'd1;
         end
         ST_ERR1: begin
            Hreadyout = 1'b0;
            Hresp     = HRESP_ERROR;
            state_nxt = ST_ERR2;
         end
         default: begin
            if (state == ST_DONE) begin
               Hrdata = mem_rdata;
               mem_we = write_q;
            end
            if (state == ST_ERR2) Hresp = HRESP_ERROR;
            state_nxt = ST_IDLE;
            if (accept) begin
               if (addr_err) begin
                  state_nxt = ST_ERR1;
               end else if (WAIT_STATES > 0) begin
                  state_nxt = ST_WAIT;
                  cnt_nxt   = CNT_LOAD;
               end else begin
                  state_nxt = ST_DONE;
               end
            end
         end
      endcase
   end

   ahb_mem_array #(
      .DEPTH      (MEM_DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mem (
      .clk_sys (Hclk),
      .we      (mem_we),
      .be      (be),
      .addr    (idx_q),
      .wdata   (Hwdata),
      .rdata   (mem_rdata)
   );

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: a zero-wait and a three-wait instance behind one driver,
// directed vector tables, hand-written reset/ready sequences and random traffic.
module tb_ahb_slave_mem;

   typedef struct {
      bit        wr;
      bit [2:0]  size;
      bit [31:0] addr;
      bit [31:0] wdata;
      bit        err;
      bit [31:0] rdata;
   } xfer_t;

   typedef struct {
      bit        rdy;
      bit        resp;
      bit [31:0] rdata;
      bit        chk_rd;
      bit [31:0] wdata;
   } cyc_t;

   logic        clk, rst;
   logic        hsel, hwrite, sel_d3, hold;
   logic [31:0] haddr, hwdata;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic        rdy0, resp0, rdy3, resp3;
   logic [31:0] rd0, rd3;
   logic        o_rdy, o_resp;
   logic [31:0] o_rd;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          ws_cur = 0;
   bit [31:0]   mdl [16];
   xfer_t       xq [$];
   xfer_t       tbl [$];

   ahb_slave_mem #(.WAIT_STATES(0)) d0 (
      .Hclk(clk), .Hreset(rst), .Hsel(hsel & ~sel_d3), .Haddr(haddr), .Htrans(htrans),
      .Hwrite(hwrite), .Hsize(hsize), .Hwdata(hwdata), .Hready(rdy0 & ~hold),
      .Hreadyout(rdy0), .Hresp(resp0), .Hrdata(rd0));

   ahb_slave_mem #(.WAIT_STATES(3)) d3 (
      .Hclk(clk), .Hreset(rst), .Hsel(hsel & sel_d3), .Haddr(haddr), .Htrans(htrans),
      .Hwrite(hwrite), .Hsize(hsize), .Hwdata(hwdata), .Hready(rdy3 & ~hold),
      .Hreadyout(rdy3), .Hresp(resp3), .Hrdata(rd3));

   assign o_rdy  = sel_d3 ? rdy3 : rdy0;
   assign o_resp = sel_d3 ? resp3 : resp0;
   assign o_rd   = sel_d3 ? rd3 : rd0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic xfer_t v(bit wr, bit [2:0] size, bit [31:0] addr, bit [31:0] wd,
                               bit err, bit [31:0] rd);
      xfer_t x;
      x.wr = wr; x.size = size; x.addr = addr; x.wdata = wd; x.err = err; x.rdata = rd;
      return x;
   endfunction

   function automatic cyc_t cy(bit r, bit s, bit [31:0] d, bit c, bit [31:0] w);
      cyc_t e;
      e.rdy = r; e.resp = s; e.rdata = d; e.chk_rd = c; e.wdata = w;
      return e;
   endfunction

   // Reference model: applies the access rules to a 16-word shadow in issue order.
   function automatic xfer_t mk_xfer(bit wr, bit [2:0] size, bit [31:0] addr, bit [31:0] wd);
      xfer_t x;
      longint idx = (addr >> 2) % (64'd1 << 26);
      int lo = addr % 4;
      int nb = 1 << size;
      x = v(wr, size, addr, wd, 1'b0, 32'h0);
      x.err = (size > 2) || (size == 1 && (addr % 2) != 0) || (size == 2 && lo != 0) ||
              (idx >= 1024);
      if (!x.err) begin
         if (wr) begin
            for (int b = 0; b < 4; b++)
               if (b >= lo && b < lo + nb) mdl[idx % 16][8*b +: 8] = wd[8*b +: 8];
         end else begin
            x.rdata = mdl[idx % 16];
         end
      end
      return x;
   endfunction

   function automatic xfer_t rand_xfer();
      int r = $urandom_range(9);
      bit [2:0] size = (r == 0) ? 3'($urandom_range(7, 3)) : 3'($urandom_range(2));
      int idx = $urandom_range(15);
      int lo;
      bit [31:0] a;
      if (size == 0)      lo = $urandom_range(3);
      else if (size == 1) lo = 2 * $urandom_range(1);
      else                lo = 0;
      if (r == 1) lo = $urandom_range(3);
      if (r == 2) idx = 1024 + $urandom_range(5000);
      a = ($urandom_range(15) << 28) + (idx << 2) + lo;
      return mk_xfer(1'($urandom_range(1)), size, a, $urandom);
   endfunction

   // Drives the queued transfers as a pipelined master and checks every data-phase cycle.
   task automatic run_queue(input bit gaps);
      cyc_t  dp [$];
      cyc_t  e;
      xfer_t x;
      int    budget = 0;
      while ((xq.size() > 0 || dp.size() > 0) && budget < 5000) begin
         @(negedge clk);
         budget++;
         if (dp.size() > 0) e = dp.pop_front();
         else               e = cy(1'b1, 1'b0, 32'h0, 1'b1, $urandom);
         check("hreadyout", 32'(o_rdy), 32'(e.rdy));
         check("hresp", 32'(o_resp), 32'(e.resp));
         if (e.chk_rd) check("hrdata", o_rd, e.rdata);
         hwdata = e.wdata;
         if (e.rdy && xq.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
            x = xq.pop_front();
            hsel = 1'b1; htrans = 2'($urandom_range(3, 2));
            haddr = x.addr; hwrite = x.wr; hsize = x.size;
            if (x.err) begin
               dp.push_back(cy(1'b0, 1'b1, 32'h0, 1'b1, $urandom));
               dp.push_back(cy(1'b1, 1'b1, 32'h0, 1'b1, $urandom));
            end else begin
               for (int i = 0; i < ws_cur; i++) dp.push_back(cy(1'b0, 1'b0, 32'h0, 1'b1, x.wdata));
               dp.push_back(cy(1'b1, 1'b0, x.rdata, !x.wr, x.wdata));
            end
         end else begin
            hsel = 1'($urandom_range(1)); htrans = 2'($urandom_range(1));
            haddr = $urandom; hwrite = 1'($urandom_range(1)); hsize = 3'($urandom_range(7));
         end
      end
      if (budget >= 5000) begin
         n_cmp++; n_bad++;
         $display("FAIL run_queue timeout: %0d cycles used, required fewer than 5000", budget);
      end
   endtask

   task automatic run_table();
      foreach (tbl[i]) xq.push_back(tbl[i]);
      tbl.delete();
      run_queue(1'b0);
   endtask

   task automatic run_random(input int n);
      for (int i = 0; i < 16; i++) xq.push_back(mk_xfer(1'b1, 3'd2, 32'(i * 4), $urandom));
      for (int i = 0; i < n; i++) xq.push_back(rand_xfer());
      run_queue(1'b1);
   endtask

   initial begin
      rst = 1'b1; hsel = 1'b0; htrans = 2'd0; haddr = '0; hwrite = 1'b0; hsize = 3'd0;
      hwdata = '0; sel_d3 = 1'b0; hold = 1'b0;
      @(negedge clk);
      check("reset_rdy0", 32'(rdy0), 32'd1);
      check("reset_resp0", 32'(resp0), 32'd0);
      check("reset_rdata0", rd0, 32'h0);
      check("reset_rdy3", 32'(rdy3), 32'd1);
      check("reset_resp3", 32'(resp3), 32'd0);
      check("reset_rdata3", rd3, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // zero wait states: {wr, size, addr, wdata, err, rdata}
      ws_cur = 0;
      tbl.push_back(v(1, 2, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0));
      tbl.push_back(v(0, 2, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF));
      tbl.push_back(v(1, 2, 32'h0000_0010, 32'h1122_3344, 0, 32'h0));
      tbl.push_back(v(1, 0, 32'h0000_0013, 32'hAA00_0000, 0, 32'h0));
      tbl.push_back(v(0, 2, 32'h0000_0010, 32'h0,         0, 32'hAA22_3344));
      tbl.push_back(v(1, 1, 32'h0000_0012, 32'h5566_0000, 0, 32'h0));
      tbl.push_back(v(0, 2, 32'h0000_0010, 32'h0,         0, 32'h5566_3344));
      tbl.push_back(v(1, 0, 32'h0000_0011, 32'h0000_7700, 0, 32'h0));
      tbl.push_back(v(0, 2, 32'hF000_0010, 32'h0,         0, 32'h5566_7744));
      tbl.push_back(v(1, 2, 32'h0000_0000, 32'h1234_5678, 0, 32'h0));
      tbl.push_back(v(1, 2, 32'h0000_0002, 32'hFFFF_FFFF, 1, 32'h0));
      tbl.push_back(v(0, 2, 32'h0000_0000, 32'h0,         0, 32'h1234_5678));
      tbl.push_back(v(0, 1, 32'h0000_0001, 32'h0,         1, 32'h0));
      tbl.push_back(v(0, 3, 32'h0000_0000, 32'h0,         1, 32'h0));
      tbl.push_back(v(0, 2, 32'h0000_1000, 32'h0,         1, 32'h0));
      tbl.push_back(v(0, 2, 32'h0FFF_FFFC, 32'h0,         1, 32'h0));
      tbl.push_back(v(0, 0, 32'h0000_0003, 32'h0,         0, 32'h1234_5678));
      tbl.push_back(v(1, 2, 32'h0000_0FFC, 32'hA5A5_5A5A, 0, 32'h0));
      tbl.push_back(v(0, 2, 32'h0000_0FFC, 32'h0,         0, 32'hA5A5_5A5A));
      run_table();
      run_random(150);

      // three wait states
      sel_d3 = 1'b1;
      ws_cur = 3;
      tbl.push_back(v(1, 2, 32'h0000_0020, 32'hCAFE_F00D, 0, 32'h0));
      tbl.push_back(v(0, 2, 32'h0000_0020, 32'h0,         0, 32'hCAFE_F00D));
      tbl.push_back(v(1, 1, 32'h0000_0021, 32'h0000_FFFF, 1, 32'h0));
      tbl.push_back(v(0, 2, 32'h0000_1000, 32'h0,         1, 32'h0));
      tbl.push_back(v(0, 2, 32'h0000_0020, 32'h0,         0, 32'hCAFE_F00D));
      run_table();

      // reset in the second wait cycle of a write discards it
      @(negedge clk);
      hsel = 1'b1; htrans = 2'd2; haddr = 32'h0000_0020; hwrite = 1'b1; hsize = 3'd2;
      @(negedge clk);
      check("rst_seq_wait1_rdy", 32'(o_rdy), 32'd0);
      hsel = 1'b0; htrans = 2'd0; hwdata = 32'h0102_0304;
      @(negedge clk);
      check("rst_seq_wait2_rdy", 32'(o_rdy), 32'd0);
      rst = 1'b1;
      #1;
      check("rst_seq_rdy", 32'(o_rdy), 32'd1);
      check("rst_seq_resp", 32'(o_resp), 32'd0);
      check("rst_seq_rdata", o_rd, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      tbl.push_back(v(0, 2, 32'h0000_0020, 32'h0, 0, 32'hCAFE_F00D));
      run_table();

      // address phase while bus Hready is low must be ignored
      @(negedge clk);
      hold = 1'b1; hsel = 1'b1; htrans = 2'd2; haddr = 32'h0000_0020; hwrite = 1'b0; hsize = 3'd2;
      @(negedge clk);
      hold = 1'b0; hsel = 1'b0; htrans = 2'd0;
      check("ignored_when_not_ready_rdy", 32'(o_rdy), 32'd1);
      check("ignored_when_not_ready_rdata", o_rd, 32'h0);

      run_random(150);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
